// File: rtl/rl_lj_pkg.sv
// rl_lj_pkg: fixed-point format constants and saturating add shared by the LJ force blocks
package rl_lj_pkg;
    localparam int LJ_FORCE_WIDTH = 32;
    localparam int LJ_FRAC_BITS   = 24;
    localparam int LJ_ACC_WIDTH   = 40;
    localparam int LJ_ID_WIDTH    = 8;
    localparam int LJ_CNT_WIDTH   = 8;

    // operands are sign-extended to 64 bits; clamps to a signed w-bit range (w <= 63)
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w,
                                                   output logic sat);
        logic signed [64:0] s, hi, lo;
        s = {a[63], a} + {b[63], b};
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (w - 1));
        sat = (s > hi) || (s < lo);
        sat_add = (s > hi) ? hi[63:0] : (s < lo) ? lo[63:0] : s[63:0];
    endfunction
endpackage

// File: rtl/rl_lj_force_acc_channel.sv
// rl_lj_force_acc_channel: per-channel pair-force accumulator, id check and completed-result hold
module rl_lj_force_acc_channel
    import rl_lj_pkg::*;
#(
    parameter int FORCE_WIDTH = LJ_FORCE_WIDTH,
    parameter int ACC_WIDTH   = LJ_ACC_WIDTH,
    parameter int ID_WIDTH    = LJ_ID_WIDTH,
    parameter int CNT_WIDTH   = LJ_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        in_last,
    input  logic [ID_WIDTH-1:0]         in_ref_id,
    input  logic [FORCE_WIDTH-1:0]      in_fx,
    input  logic [FORCE_WIDTH-1:0]      in_fy,
    input  logic [FORCE_WIDTH-1:0]      in_fz,
    output logic                        in_ready,
    input  logic                        grant,
    output logic                        hold_valid,
    output logic [ID_WIDTH-1:0]         hold_id,
    output logic signed [ACC_WIDTH-1:0] hold_x,
    output logic signed [ACC_WIDTH-1:0] hold_y,
    output logic signed [ACC_WIDTH-1:0] hold_z,
    output logic [CNT_WIDTH-1:0]        hold_cnt,
    output logic                        hold_sat,
    output logic                        err_id_mismatch
);
    logic signed [ACC_WIDTH-1:0]   acc_x, acc_y, acc_z, nx, ny, nz;
    logic signed [FORCE_WIDTH-1:0] fx, fy, fz;
    logic signed [63:0]            sum_x, sum_y, sum_z;
    logic                          sat_x, sat_y, sat_z, sat_c, nsat, busy, take;
    logic [CNT_WIDTH-1:0]          cnt, ncnt;
    logic [ID_WIDTH-1:0]           cur_id;

    assign fx = in_fx;
    assign fy = in_fy;
    assign fz = in_fz;
    assign in_ready = ~hold_valid;
    assign take = in_valid & in_ready;

    always_comb begin
        sum_x = sat_add(64'(acc_x), 64'(fx), ACC_WIDTH, sat_x);
        sum_y = sat_add(64'(acc_y), 64'(fy), ACC_WIDTH, sat_y);
        sum_z = sat_add(64'(acc_z), 64'(fz), ACC_WIDTH, sat_z);
        nx = sum_x[ACC_WIDTH-1:0];
        ny = sum_y[ACC_WIDTH-1:0];
        nz = sum_z[ACC_WIDTH-1:0];
        nsat = sat_c | sat_x | sat_y | sat_z;
        ncnt = &cnt ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_x <= '0;
            acc_y <= '0;
            acc_z <= '0;
            cnt <= '0;
            sat_c <= 1'b0;
            busy <= 1'b0;
            cur_id <= '0;
            hold_valid <= 1'b0;
            hold_id <= '0;
            hold_x <= '0;
            hold_y <= '0;
            hold_z <= '0;
            hold_cnt <= '0;
            hold_sat <= 1'b0;
            err_id_mismatch <= 1'b0;
        end else begin
            if (grant) hold_valid <= 1'b0;
            if (take) begin
                if (!busy) cur_id <= in_ref_id;
                if (busy && in_ref_id != cur_id) err_id_mismatch <= 1'b1;
                if (in_last) begin
                    hold_valid <= 1'b1;
                    hold_id <= busy ? cur_id : in_ref_id;
                    hold_x <= nx;
                    hold_y <= ny;
                    hold_z <= nz;
                    hold_cnt <= ncnt;
                    hold_sat <= nsat;
                    acc_x <= '0;
                    acc_y <= '0;
                    acc_z <= '0;
                    cnt <= '0;
                    sat_c <= 1'b0;
                    busy <= 1'b0;
                end else begin
                    acc_x <= nx;
                    acc_y <= ny;
                    acc_z <= nz;
                    cnt <= ncnt;
                    sat_c <= nsat;
                    busy <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/rl_lj_force_accumulator.sv
// rl_lj_force_accumulator: multi-channel LJ force summation with round-robin merge onto one output stream
module rl_lj_force_accumulator
    import rl_lj_pkg::*;
#(
    parameter int NUM_CHANNEL = 4,
    parameter int FORCE_WIDTH = LJ_FORCE_WIDTH,
    parameter int ACC_WIDTH   = LJ_ACC_WIDTH,
    parameter int ID_WIDTH    = LJ_ID_WIDTH,
    parameter int CNT_WIDTH   = LJ_CNT_WIDTH,
    localparam int CW = $clog2(NUM_CHANNEL)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CHANNEL-1:0]          in_valid,
    input  logic [NUM_CHANNEL-1:0]          in_last,
    input  logic [NUM_CHANNEL*ID_WIDTH-1:0] in_ref_id,
    input  logic [NUM_CHANNEL*FORCE_WIDTH-1:0] in_fx,
    input  logic [NUM_CHANNEL*FORCE_WIDTH-1:0] in_fy,
    input  logic [NUM_CHANNEL*FORCE_WIDTH-1:0] in_fz,
    output logic [NUM_CHANNEL-1:0]          in_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CW-1:0]                   out_channel,
    output logic [ID_WIDTH-1:0]             out_ref_id,
    output logic [ACC_WIDTH-1:0]            out_fx,
    output logic [ACC_WIDTH-1:0]            out_fy,
    output logic [ACC_WIDTH-1:0]            out_fz,
    output logic [CNT_WIDTH-1:0]            out_pair_cnt,
    output logic                            out_sat,
    output logic [NUM_CHANNEL-1:0]          err_id_mismatch
);
    logic [NUM_CHANNEL-1:0]      hold_valid, hold_sat, grant;
    logic [ID_WIDTH-1:0]         h_id [NUM_CHANNEL];
    logic signed [ACC_WIDTH-1:0] h_x [NUM_CHANNEL];
    logic signed [ACC_WIDTH-1:0] h_y [NUM_CHANNEL];
    logic signed [ACC_WIDTH-1:0] h_z [NUM_CHANNEL];
    logic [CNT_WIDTH-1:0]        h_cnt [NUM_CHANNEL];
    logic [CW-1:0]               last_grant, win;
    logic                        found, load;

    for (genvar g = 0; g < NUM_CHANNEL; g++) begin : g_ch
        rl_lj_force_acc_channel #(
            .FORCE_WIDTH(FORCE_WIDTH),
            .ACC_WIDTH(ACC_WIDTH),
            .ID_WIDTH(ID_WIDTH),
            .CNT_WIDTH(CNT_WIDTH)
        ) u_ch (
            .clk(clk),
            .rst(rst),
            .in_valid(in_valid[g]),
            .in_last(in_last[g]),
            .in_ref_id(in_ref_id[g*ID_WIDTH +: ID_WIDTH]),
            .in_fx(in_fx[g*FORCE_WIDTH +: FORCE_WIDTH]),
            .in_fy(in_fy[g*FORCE_WIDTH +: FORCE_WIDTH]),
            .in_fz(in_fz[g*FORCE_WIDTH +: FORCE_WIDTH]),
            .in_ready(in_ready[g]),
            .grant(grant[g]),
            .hold_valid(hold_valid[g]),
            .hold_id(h_id[g]),
            .hold_x(h_x[g]),
            .hold_y(h_y[g]),
            .hold_z(h_z[g]),
            .hold_cnt(h_cnt[g]),
            .hold_sat(hold_sat[g]),
            .err_id_mismatch(err_id_mismatch[g])
        );
    end

    // rotate the search so the channel after the last winner has top priority
    always_comb begin
        int j;
        j = 0;
        found = 1'b0;
        win = '0;
        for (int i = 1; i <= NUM_CHANNEL; i++) begin
            j = (int'(last_grant) + i) % NUM_CHANNEL;
            if (!found && hold_valid[CW'(j)]) begin
                found = 1'b1;
                win = CW'(j);
            end
        end
    end

    assign load = ~out_valid | out_ready;
    assign grant = (load && found) ? (NUM_CHANNEL'(1) << win) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_channel <= '0;
            out_ref_id <= '0;
            out_fx <= '0;
            out_fy <= '0;
            out_fz <= '0;
            out_pair_cnt <= '0;
            out_sat <= 1'b0;
            last_grant <= CW'(NUM_CHANNEL - 1);
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out_channel <= win;
                out_ref_id <= h_id[win];
                out_fx <= h_x[win];
                out_fy <= h_y[win];
                out_fz <= h_z[win];
                out_pair_cnt <= h_cnt[win];
                out_sat <= hold_sat[win];
                last_grant <= win;
            end
        end
    end
endmodule

// File: tb/tb_rl_lj_force_accumulator.sv
// tb_rl_lj_force_accumulator: directed checks of accumulation, arbitration, back-pressure, saturation and reset
module tb_rl_lj_force_accumulator;
    localparam int NC = 4;
    localparam int FW = 32;
    localparam int AW = 40;
    localparam int IW = 8;
    localparam int CN = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NC-1:0]   in_valid = '0, in_last = '0, in_ready, err_id_mismatch;
    logic [NC*IW-1:0] in_ref_id = '0;
    logic [NC*FW-1:0] in_fx = '0, in_fy = '0, in_fz = '0;
    logic            out_valid, out_ready = 1'b1, out_sat;
    logic [1:0]      out_channel;
    logic [IW-1:0]   out_ref_id;
    logic [AW-1:0]   out_fx, out_fy, out_fz;
    logic [CN-1:0]   out_pair_cnt;
    int n_cmp = 0;
    int n_err = 0;

    rl_lj_force_accumulator #(
        .NUM_CHANNEL(NC), .FORCE_WIDTH(FW), .ACC_WIDTH(AW), .ID_WIDTH(IW), .CNT_WIDTH(CN)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_last(in_last), .in_ref_id(in_ref_id),
        .in_fx(in_fx), .in_fy(in_fy), .in_fz(in_fz), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
        .out_ref_id(out_ref_id), .out_fx(out_fx), .out_fy(out_fy), .out_fz(out_fz),
        .out_pair_cnt(out_pair_cnt), .out_sat(out_sat), .err_id_mismatch(err_id_mismatch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input int c, input logic [FW-1:0] f, input logic [IW-1:0] id, input logic last);
        in_valid[c] = 1'b1;
        in_last[c] = last;
        in_ref_id[c*IW +: IW] = id;
        in_fx[c*FW +: FW] = f;
        in_fy[c*FW +: FW] = f;
        in_fz[c*FW +: FW] = '0;
        step();
        in_valid[c] = 1'b0;
        in_last[c] = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_in_ready", 64'(in_ready), 64'hf);
        chk("rst_err", 64'(err_id_mismatch), 0);
        rst = 1'b1;
        step();

        pair(0, 32'd5, 8'h21, 1'b0);
        pair(0, -32'sd2, 8'h21, 1'b0);
        pair(0, 32'd10, 8'h21, 1'b1);
        chk("t1_not_yet", 64'(out_valid), 0);
        step();
        chk("t1_valid", 64'(out_valid), 1);
        chk("t1_fx", 64'(out_fx), 13);
        chk("t1_fy", 64'(out_fy), 13);
        chk("t1_fz", 64'(out_fz), 0);
        chk("t1_cnt", 64'(out_pair_cnt), 3);
        chk("t1_ch", 64'(out_channel), 0);
        chk("t1_id", 64'(out_ref_id), 64'h21);
        chk("t1_sat", 64'(out_sat), 0);
        step();
        chk("t1_drain", 64'(out_valid), 0);

        pair(2, 32'd1, 8'd7, 1'b0);
        pair(2, 32'd1, 8'd7, 1'b0);
        pair(2, 32'd1, 8'd9, 1'b1);
        step();
        chk("t5_valid", 64'(out_valid), 1);
        chk("t5_id", 64'(out_ref_id), 7);
        chk("t5_cnt", 64'(out_pair_cnt), 3);
        chk("t5_ch", 64'(out_channel), 2);
        chk("t5_err", 64'(err_id_mismatch), 64'b0100);
        pair(2, 32'd4, 8'd3, 1'b1);
        step();
        chk("t5_fx2", 64'(out_fx), 4);
        chk("t5_sticky", 64'(err_id_mismatch), 64'b0100);

        pair(3, 32'd100, 8'd5, 1'b0);
        pair(3, 32'd100, 8'd5, 1'b0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t6_out_valid", 64'(out_valid), 0);
        chk("t6_in_ready", 64'(in_ready), 64'hf);
        chk("t6_fx", 64'(out_fx), 0);
        chk("t6_id", 64'(out_ref_id), 0);
        chk("t6_cnt", 64'(out_pair_cnt), 0);
        chk("t6_err", 64'(err_id_mismatch), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_quiet", 64'(out_valid), 0);
        end
        pair(3, 32'd7, 8'd6, 1'b1);
        step();
        chk("t6_ch", 64'(out_channel), 3);
        chk("t6_fx_fresh", 64'(out_fx), 7);
        chk("t6_cnt_fresh", 64'(out_pair_cnt), 1);
        step();

        for (int r = 0; r < 2; r++) begin
            in_valid = '1;
            in_last = '1;
            for (int c = 0; c < NC; c++) begin
                in_fx[c*FW +: FW] = FW'(c + 1);
                in_fy[c*FW +: FW] = '0;
                in_ref_id[c*IW +: IW] = IW'(8'h40 + c);
            end
            step();
            in_valid = '0;
            in_last = '0;
            for (int c = 0; c < NC; c++) begin
                step();
                chk("t2_valid", 64'(out_valid), 1);
                chk("t2_ch", 64'(out_channel), 64'(c));
                chk("t2_fx", 64'(out_fx), 64'(c + 1));
            end
            step();
            chk("t2_idle", 64'(out_valid), 0);
        end

        out_ready = 1'b0;
        pair(1, 32'd20, 8'h11, 1'b0);
        pair(1, 32'd30, 8'h11, 1'b1);
        chk("t3_hold_stall", 64'(in_ready[1]), 0);
        step();
        chk("t3_first", 64'(out_fx), 50);
        pair(1, 32'd40, 8'h12, 1'b1);
        for (int i = 0; i < 8; i++) step();
        chk("t3_stable_valid", 64'(out_valid), 1);
        chk("t3_stable_fx", 64'(out_fx), 50);
        chk("t3_stable_id", 64'(out_ref_id), 64'h11);
        chk("t3_ready_low", 64'(in_ready[1]), 0);
        out_ready = 1'b1;
        step();
        chk("t3_second_valid", 64'(out_valid), 1);
        chk("t3_second_fx", 64'(out_fx), 40);
        chk("t3_second_id", 64'(out_ref_id), 64'h12);
        chk("t3_ready_back", 64'(in_ready[1]), 1);
        step();
        chk("t3_drain", 64'(out_valid), 0);

        for (int i = 0; i < 300; i++) pair(0, 32'h7FFF_FFFF, 8'h30, i == 299);
        step();
        chk("t4_fx", 64'(out_fx), 64'h7F_FFFF_FFFF);
        chk("t4_sat", 64'(out_sat), 1);
        chk("t4_cnt", 64'(out_pair_cnt), 64'hFF);
        pair(0, 32'd9, 8'h31, 1'b1);
        step();
        chk("t4_clean_fx", 64'(out_fx), 9);
        chk("t4_clean_sat", 64'(out_sat), 0);
        pair(3, -32'sd3, 8'h32, 1'b1);
        step();
        chk("t4_neg_fx", 64'(out_fx), 64'hFF_FFFF_FFFD);
        chk("t4_neg_sat", 64'(out_sat), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
